// File: rtl/xalu_ctrl.sv
// HI/LO multiply/divide controller for the E stage.
// Multiplies complete after a fixed MUL_LAT latency; divides use a 32-step restoring
// divider framed by a prepare cycle (magnitudes) and a fix-up cycle (signs).
module xalu_ctrl #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic        Clk,
  input  logic        Clr_n,
  input  logic        E_Start,
  input  logic [2:0]  E_Op,
  input  logic [31:0] E_RsData,
  input  logic [31:0] E_RtData,
  input  logic        dm_stall,
  input  logic        exp_flush,
  output logic        E_XALU_Busy,
  output logic        XALU_Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StMul     = 3'd1;
  localparam logic [2:0] StDivPrep = 3'd2;
  localparam logic [2:0] StDivIter = 3'd3;
  localparam logic [2:0] StDivFix  = 3'd4;

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        sgn_q, sgn_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        div0_q, div0_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] divb_q, divb_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        accept;
  logic [63:0] mul_a, mul_b, prod;
  logic [32:0] rem_sh, rem_sub;
  logic        q_bit;

  assign E_XALU_Busy = (state_q != StIdle);
  assign XALU_Done   = done_q;
  assign HI          = hi_q;
  assign LO          = lo_q;

  // Datapath helpers: sign-extended product and one restoring-division step.
  always_comb begin
    accept  = (state_q == StIdle) && E_Start && !dm_stall && !exp_flush && (E_Op <= OpMtlo);
    mul_a   = {{32{sgn_q & op_a_q[31]}}, op_a_q};
    mul_b   = {{32{sgn_q & op_b_q[31]}}, op_b_q};
    prod    = mul_a * mul_b;
    rem_sh  = {rem_q, quo_q[31]};
    q_bit   = (rem_sh >= {1'b0, divb_q});
    rem_sub = q_bit ? (rem_sh - {1'b0, divb_q}) : rem_sh;
  end

  // Next-state logic for the FSM, operand latches, divider and HI/LO.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sgn_d   = sgn_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    div0_d  = div0_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    divb_d  = divb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (E_Op)
            OpMult, OpMultu: begin
              op_a_d  = E_RsData;
              op_b_d  = E_RtData;
              sgn_d   = (E_Op == OpMult);
              cnt_d   = 6'(MUL_LAT - 1);
              state_d = StMul;
            end
            OpDiv, OpDivu: begin
              op_a_d  = E_RsData;
              op_b_d  = E_RtData;
              sgn_d   = (E_Op == OpDiv);
              state_d = StDivPrep;
            end
            OpMthi:  hi_d = E_RsData;
            OpMtlo:  lo_d = E_RsData;
            default: ;
          endcase
        end
      end
      StMul: begin
        if (cnt_q == 6'd0) begin
          {hi_d, lo_d} = prod;
          done_d       = 1'b1;
          state_d      = StIdle;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      StDivPrep: begin
        // Most-negative dividend negates to itself, which is its correct unsigned magnitude.
        quo_d   = (sgn_q && op_a_q[31]) ? (32'd0 - op_a_q) : op_a_q;
        divb_d  = (sgn_q && op_b_q[31]) ? (32'd0 - op_b_q) : op_b_q;
        q_neg_d = sgn_q && (op_a_q[31] ^ op_b_q[31]);
        r_neg_d = sgn_q && op_a_q[31];
        div0_d  = (op_b_q == 32'd0);
        rem_d   = 32'd0;
        cnt_d   = 6'd32;
        state_d = StDivIter;
      end
      StDivIter: begin
        rem_d = rem_sub[31:0];
        quo_d = {quo_q[30:0], q_bit};
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = StDivFix;
      end
      StDivFix: begin
        if (div0_q) begin
          lo_d = 32'hFFFF_FFFF;
          hi_d = op_a_q;
        end else begin
          lo_d = q_neg_q ? (32'd0 - quo_q) : quo_q;
          hi_d = r_neg_q ? (32'd0 - rem_q) : rem_q;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge Clk) begin
    if (!Clr_n) begin
      state_q <= StIdle;
      cnt_q   <= 6'd0;
      op_a_q  <= 32'd0;
      op_b_q  <= 32'd0;
      sgn_q   <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      div0_q  <= 1'b0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
      divb_q  <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sgn_q   <= sgn_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      div0_q  <= div0_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      divb_q  <= divb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

endmodule
